// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, enable levels,
// reset PC and the fetch-state encoding.
package inst_fetch_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic RstDisable  = 1'b0;
    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    localparam int InstAddrBus = 32;
    localparam int InstBus     = 32;

    localparam logic [InstAddrBus-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'b00,
        IF_REQ  = 2'b01,
        IF_HOLD = 2'b10,
        IF_DROP = 2'b11
    } if_state_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ctrl/decode controls, ROM ce/ack handshake and the IF/ID outputs.
// master = the fetch stage, slave = its environment (ctrl, decode, ROM).
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              stall_i;
    logic              flush_i;
    logic [ADDR_W-1:0] new_pc_i;
    logic              branch_flag_i;
    logic [ADDR_W-1:0] branch_target_i;
    logic              rom_ce_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ack_i;
    logic [INST_W-1:0] rom_data_i;
    logic [ADDR_W-1:0] if_pc_o;
    logic [INST_W-1:0] if_inst_o;
    logic              if_valid_o;

    modport master (
        input  stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
        input  rom_ack_i, rom_data_i,
        output rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
    );

    modport slave (
        output stall_i, flush_i, new_pc_i, branch_flag_i, branch_target_i,
        output rom_ack_i, rom_data_i,
        input  rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
    );
endinterface

// File: rtl/inst_fetch_hold_buf.sv
// if_hold_buf: one-entry {pc, inst, full} buffer that parks an instruction the ROM
// returned while the pipeline was stalled. Only the full flag is reset.
module if_hold_buf
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              pop,
    input  logic [ADDR_W-1:0] ld_pc,
    input  logic [INST_W-1:0] ld_inst,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            full <= 1'b0;
        end else if (clear || pop) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            pc   <= ld_pc;
            inst <= ld_inst;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC generation, ROM ce/ack fetch and IF/ID presentation with stall,
// flush and MIPS delay-slot branches. Optional `IF_PERF_CNT_EN adds fetch/bubble counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              ADDR_W   = InstAddrBus,
    parameter int              INST_W   = InstBus,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic        clk,
    input  logic        rst,
    inst_fetch_if.master bus
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    if_state_t         state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drop_pc;
    logic [ADDR_W-1:0] br_target;
    logic              br_pend;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] flush_pc;
    logic [ADDR_W-1:0] branch_dest;
    logic              ack_go;
    logic              hold_go;
    logic              deliver;
    logic              buf_load;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_pc;
    logic [INST_W-1:0] buf_inst;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

    // A branch pulse in the same cycle as a delivery is consumed directly, so the
    // instruction being delivered now is the delay slot and the target comes next.
    always_comb begin
        flush_pc    = word_align(bus.new_pc_i);
        branch_dest = bus.branch_flag_i ? word_align(bus.branch_target_i) : br_target;
        next_pc     = (bus.branch_flag_i || br_pend) ? branch_dest : pc + ADDR_W'(4);
        ack_go      = (state == IF_REQ) && bus.rom_ack_i && !bus.stall_i && !bus.flush_i;
        hold_go     = (state == IF_HOLD) && buf_full && !bus.stall_i && !bus.flush_i;
        deliver     = ack_go || hold_go;
        buf_load    = (state == IF_REQ) && bus.rom_ack_i && bus.stall_i && !bus.flush_i;
    end

    if_hold_buf #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_hold_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (buf_load),
        .clear   (bus.flush_i),
        .pop     (hold_go),
        .ld_pc   (pc),
        .ld_inst (bus.rom_data_i),
        .pc      (buf_pc),
        .inst    (buf_inst),
        .full    (buf_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state          <= IF_IDLE;
            pc             <= RESET_PC;
            br_pend        <= 1'b0;
            bus.rom_ce_o   <= ChipDisable;
            bus.rom_addr_o <= '0;
            bus.if_pc_o    <= '0;
            bus.if_inst_o  <= '0;
            bus.if_valid_o <= 1'b0;
        end else begin
            if (bus.flush_i || deliver) begin
                br_pend <= 1'b0;
            end else if (bus.branch_flag_i) begin
                br_pend <= 1'b1;
            end

            if (deliver) begin
                bus.if_pc_o    <= ack_go ? pc : buf_pc;
                bus.if_inst_o  <= ack_go ? bus.rom_data_i : buf_inst;
                bus.if_valid_o <= 1'b1;
                pc             <= next_pc;
                bus.rom_addr_o <= next_pc;
                bus.rom_ce_o   <= ChipEnable;
                state          <= IF_REQ;
            end else if (bus.flush_i) begin
                bus.if_valid_o <= 1'b0;
                // An unanswered request must complete on the bus before redirecting.
                if ((state == IF_REQ || state == IF_DROP) && !bus.rom_ack_i) begin
                    state <= IF_DROP;
                end else begin
                    pc             <= flush_pc;
                    bus.rom_addr_o <= flush_pc;
                    bus.rom_ce_o   <= ChipEnable;
                    state          <= IF_REQ;
                end
            end else begin
                case (state)
                    IF_IDLE: begin
                        bus.rom_ce_o   <= ChipEnable;
                        bus.rom_addr_o <= pc;
                        state          <= IF_REQ;
                    end
                    IF_REQ: begin
                        if (bus.rom_ack_i && bus.stall_i) begin
                            bus.rom_ce_o <= ChipDisable;
                            state        <= IF_HOLD;
                        end else if (!bus.rom_ack_i && !bus.stall_i) begin
                            bus.if_valid_o <= 1'b0;
                        end
                    end
                    IF_DROP: begin
                        if (bus.rom_ack_i) begin
                            pc             <= drop_pc;
                            bus.rom_addr_o <= drop_pc;
                            state          <= IF_REQ;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.flush_i) begin
            drop_pc <= flush_pc;
        end
        if (bus.branch_flag_i && !deliver) begin
            br_target <= word_align(bus.branch_target_i);
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (deliver) begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
            if (!bus.if_valid_o && !bus.stall_i) begin
                bubble_cnt_o <= bubble_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed boot/stall/branch/flush/reset
// scenarios, then randomized traffic against a flag-based fetch model.
module tb_inst_fetch;

    logic clk = 1'b1;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    inst_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    int n_cmp;
    int n_bad;

    // model: fetch progress as flags rather than a state machine
    bit          m_started, m_ce, m_held, m_squash, m_br;
    logic [31:0] m_pc, m_addr, m_restart, m_br_tgt, m_held_inst;
    logic [31:0] e_pc, e_inst;
    bit          e_valid;
    int unsigned e_fetch, e_bubble;

    // ROM behaviour
    int unsigned wait_left, wait_lo, wait_hi;
    bit          late_ack;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic model_reset();
        m_started = 0; m_ce = 0; m_held = 0; m_squash = 0; m_br = 0;
        m_pc = 32'h0; m_addr = 32'h0; m_restart = 32'h0; m_br_tgt = 32'h0; m_held_inst = 32'h0;
        e_pc = 32'h0; e_inst = 32'h0; e_valid = 0;
        e_fetch = 0; e_bubble = 0;
        wait_left = 0;
    endtask

    task automatic model_step(input bit s, input bit f, input logic [31:0] np,
                              input bit ack, input logic [31:0] data,
                              input bit b, input logic [31:0] bt);
        logic [31:0] fpc, nxt;
        bit adv;
        fpc = {np[31:2], 2'b00};
        nxt = b ? {bt[31:2], 2'b00} : (m_br ? m_br_tgt : m_pc + 32'd4);
        adv = 0;
        if (!e_valid && !s) e_bubble++;
        if (!m_started) begin
            m_started = 1;
            m_ce = 1;
            if (f) begin
                m_pc = fpc;
                e_valid = 0;
            end
            m_addr = m_pc;
        end else if (f) begin
            e_valid = 0;
            if (!m_held && !ack) begin
                m_squash = 1;
                m_restart = fpc;
            end else begin
                m_squash = 0; m_held = 0; m_pc = fpc; m_addr = fpc; m_ce = 1;
            end
        end else if (m_squash) begin
            if (ack) begin
                m_squash = 0; m_pc = m_restart; m_addr = m_restart;
            end
        end else if (m_held) begin
            if (!s) begin
                e_pc = m_pc; e_inst = m_held_inst; e_valid = 1;
                m_held = 0; m_ce = 1; adv = 1;
            end
        end else if (ack && !s) begin
            e_pc = m_pc; e_inst = data; e_valid = 1; adv = 1;
        end else if (ack) begin
            m_held = 1; m_held_inst = data; m_ce = 0;
        end else if (!s) begin
            e_valid = 0;
        end
        if (adv) begin
            m_pc = nxt; m_addr = nxt; e_fetch++;
        end
        if (f || adv) m_br = 0;
        else if (b) begin
            m_br = 1;
            m_br_tgt = {bt[31:2], 2'b00};
        end
    endtask

    task automatic check_outputs();
        chk_val("rom_ce",   bus.rom_ce_o,   m_ce);
        chk_val("rom_addr", bus.rom_addr_o, m_addr);
        chk_val("if_pc",    bus.if_pc_o,    e_pc);
        chk_val("if_inst",  bus.if_inst_o,  e_inst);
        chk_val("if_valid", bus.if_valid_o, e_valid);
`ifdef IF_PERF_CNT_EN
        chk_val("fetch_cnt",  fetch_cnt,  e_fetch);
        chk_val("bubble_cnt", bubble_cnt, e_bubble);
`endif
    endtask

    task automatic step(input bit s, input bit f, input logic [31:0] np,
                        input bit b, input logic [31:0] bt);
        bit ack;
        logic [31:0] data;
        ack = 0;
        if (m_ce) begin
            if (wait_left == 0) begin
                ack = 1;
                wait_left = $urandom_range(wait_hi, wait_lo);
            end else begin
                wait_left--;
            end
        end
        data = ack ? rom_word(m_addr) : $urandom();
        if (late_ack) ack = 1;
        late_ack = 0;
        bus.stall_i = s;
        bus.flush_i = f;
        bus.new_pc_i = np;
        bus.branch_flag_i = b;
        bus.branch_target_i = bt;
        bus.rom_ack_i = ack;
        bus.rom_data_i = data;
        @(posedge clk);
        model_step(s, f, np, ack, data, b, bt);
        #1;
        check_outputs();
    endtask

    task automatic idle_step();
        step(0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic run_to_addr(input logic [31:0] target);
        for (int k = 0; k < 64 && m_addr != target; k++) idle_step();
        chk_val("reach_addr", bus.rom_addr_o, target);
    endtask

    task automatic async_reset();
        #3;
        rst = 1;
        bus.rom_ack_i = 1;
        bus.rom_data_i = $urandom();
        #1;
        chk_val("rst_rom_ce",   bus.rom_ce_o,   0);
        chk_val("rst_rom_addr", bus.rom_addr_o, 0);
        chk_val("rst_if_pc",    bus.if_pc_o,    0);
        chk_val("rst_if_inst",  bus.if_inst_o,  0);
        chk_val("rst_if_valid", bus.if_valid_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        chk_val("rst_hold_ce", bus.rom_ce_o, 0);
        #3;
        rst = 0;
        late_ack = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1;
        bus.stall_i = 0; bus.flush_i = 0; bus.new_pc_i = 0;
        bus.branch_flag_i = 0; bus.branch_target_i = 0;
        bus.rom_ack_i = 0; bus.rom_data_i = 0;
        model_reset();
        wait_lo = 0; wait_hi = 0; late_ack = 0;

        #15;
        check_outputs();
        #180;
        rst = 0;

        // boot with a 0-wait ROM
        idle_step();
        chk_val("boot_addr0", bus.rom_addr_o, 32'h0);
        chk_val("boot_valid0", bus.if_valid_o, 0);
        idle_step();
        chk_val("boot_addr4", bus.rom_addr_o, 32'h4);
        chk_val("boot_pc0", bus.if_pc_o, 32'h0);
        chk_val("boot_valid1", bus.if_valid_o, 1);
        idle_step();
        chk_val("boot_addr8", bus.rom_addr_o, 32'h8);
        chk_val("boot_pc4", bus.if_pc_o, 32'h4);

        // stall while the ROM answers 0x10
        run_to_addr(32'h10);
        step(1, 0, 32'h0, 0, 32'h0);
        chk_val("stall_ce_off", bus.rom_ce_o, 0);
        chk_val("stall_pc_frozen", bus.if_pc_o, 32'hC);
        step(1, 0, 32'h0, 0, 32'h0);
        step(1, 0, 32'h0, 0, 32'h0);
        chk_val("stall_pc_still", bus.if_pc_o, 32'hC);
        idle_step();
        chk_val("unstall_pc", bus.if_pc_o, 32'h10);
        chk_val("unstall_inst", bus.if_inst_o, rom_word(32'h10));
        chk_val("unstall_addr", bus.rom_addr_o, 32'h14);

        // branch decoded at 0x20 -> slot 0x24 -> target 0x100
        for (int k = 0; k < 64 && !(e_valid && e_pc == 32'h20); k++) idle_step();
        chk_val("br_at_0x20", bus.if_pc_o, 32'h20);
        step(0, 0, 32'h0, 1, 32'h100);
        chk_val("br_slot", bus.if_pc_o, 32'h24);
        idle_step();
        chk_val("br_target", bus.if_pc_o, 32'h100);
        idle_step();
        chk_val("br_target4", bus.if_pc_o, 32'h104);

        // flush during a 2-wait-state request to 0x30
        wait_lo = 2; wait_hi = 2;
        step(0, 1, 32'h30, 0, 32'h0);
        chk_val("fl_addr30", bus.rom_addr_o, 32'h30);
        idle_step();
        step(0, 1, 32'h200, 0, 32'h0);
        chk_val("fl_valid0", bus.if_valid_o, 0);
        chk_val("fl_addr_held", bus.rom_addr_o, 32'h30);
        idle_step();
        chk_val("fl_addr200", bus.rom_addr_o, 32'h200);
        chk_val("fl_discard", bus.if_valid_o, 0);
        idle_step();
        idle_step();
        idle_step();
        chk_val("fl_deliver_pc", bus.if_pc_o, 32'h200);
        chk_val("fl_deliver_valid", bus.if_valid_o, 1);

        // async reset while parked in HOLD
        wait_lo = 0; wait_hi = 0;
        for (int k = 0; k < 8 && !m_held; k++) step(1, 0, 32'h0, 0, 32'h0);
        chk_val("hold_entered", bus.rom_ce_o, 0);
        step(1, 0, 32'h0, 0, 32'h0);
        async_reset();
        idle_step();
        chk_val("rst_restart_addr", bus.rom_addr_o, 32'h0);
        chk_val("rst_late_ack", bus.if_valid_o, 0);
        idle_step();
        chk_val("rst_first_pc", bus.if_pc_o, 32'h0);
        chk_val("rst_first_valid", bus.if_valid_o, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                wait_lo = 0;
                wait_hi = $urandom_range(3, 0);
            end
            if (c % 1000 == 999) begin
                async_reset();
            end else begin
                step(($urandom_range(3, 0) == 0), ($urandom_range(19, 0) == 0), $urandom(),
                     ($urandom_range(9, 0) == 0), $urandom());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
